gemm_loader: RTL and testbench

Host-side initiator that drives the write/start/done interface of the 16x16 GEMM core.
- Accepts a valid/ready element stream: 256 m1 elements, then 256 m2 elements, both row-major.
- Converts each accepted element into a core write, pulses start, and waits for done.
- Returns the core's sum_out on a valid/ready result channel, with a timeout error path.
- Sits between the DMA/stream fabric and the GEMM core.

---
 rtl/gemm_loader.sv | 171 +++++++++++++++++
 tb/tb_gemm_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_loader.sv
// gemm_loader: host-side initiator that streams two NxN matrices into the GEMM core,
// starts it, and returns its sum (or a timeout error) on a valid/ready result channel.
`default_nettype none

module gemm_loader #(
  parameter int N       = 16,
  parameter int DW      = 21,
  parameter int AW      = 8,
  parameter int TIMEOUT = 8192
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          cmd_rerun,
  output logic          wr_en,
  output logic [1:0]    wr_sel,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          start,
  input  logic          done,
  input  logic [31:0]   sum_in,
  output logic          r_valid,
  input  logic          r_ready,
  output logic [31:0]   r_data,
  output logic          r_err,
  output logic          busy
);

  localparam int IW = AW + 2;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(2 * N * N - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    RESULT = 3'd4
  } state_t;

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] tmo_q;
  logic          done_q;
  logic          s_ready_q;
  logic          wr_en_q;
  logic [1:0]    wr_sel_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic          start_q;
  logic          r_valid_q;
  logic [31:0]   r_data_q;
  logic          r_err_q;
  logic          busy_q;

  logic accept;
  logic last_elem;
  logic done_rise;

  assign accept    = s_valid && s_ready_q;
  assign last_elem = (idx_q == LAST_IDX);
  // A level left high by the previous run must not complete this one.
  assign done_rise = done && !done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      s_ready_q <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= 2'b00;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      start_q   <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_err_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q  <= done;
      wr_en_q <= 1'b0;
      start_q <= 1'b0;

      if (accept) begin
        wr_en_q   <= 1'b1;
        wr_sel_q  <= {1'b0, idx_q[AW]};
        wr_addr_q <= idx_q[AW-1:0];
        wr_data_q <= s_data;
        idx_q     <= last_elem ? '0 : idx_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end else if (cmd_rerun) begin
            state_q   <= START;
            start_q   <= 1'b1;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        LOAD: begin
          if (accept && last_elem) begin
            state_q   <= START;
            s_ready_q <= 1'b0;
          end
        end
        START: begin
          // A rerun enters with the pulse already out; a load issues it here,
          // one cycle after the final write.
          if (start_q) begin
            state_q <= WAIT;
          end else begin
            start_q <= 1'b1;
          end
        end
        WAIT: begin
          if (done_rise) begin
            r_data_q  <= sum_in;
            r_err_q   <= 1'b0;
            r_valid_q <= 1'b1;
            tmo_q     <= '0;
            state_q   <= RESULT;
          end else if (tmo_q == TMO_LAST) begin
            r_data_q  <= '0;
            r_err_q   <= 1'b1;
            r_valid_q <= 1'b1;
            tmo_q     <= '0;
            state_q   <= RESULT;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RESULT: begin
          if (r_ready) begin
            r_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign wr_en   = wr_en_q;
  assign wr_sel  = wr_sel_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign start   = start_q;
  assign r_valid = r_valid_q;
  assign r_data  = r_data_q;
  assign r_err   = r_err_q;
  assign busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_gemm_loader.sv
// tb_gemm_loader: drives matrix streams into gemm_loader against a behavioural GEMM core
// and scores write traffic, start timing and results.
`default_nettype none

module tb_gemm_loader;

  localparam int TIMEOUT = 8192;
  localparam int LAT     = 12;

  typedef logic signed [20:0] mat_t [256];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, cmd_rerun;
  logic [20:0] s_data;
  logic        wr_en, start, done, r_valid, r_ready, r_err, busy;
  logic [1:0]  wr_sel;
  logic [7:0]  wr_addr;
  logic [20:0] wr_data;
  logic [31:0] sum_in, r_data;

  gemm_loader #(.N(16), .DW(21), .AW(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .cmd_rerun(cmd_rerun),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .done(done), .sum_in(sum_in),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_err(r_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mat_sum(input mat_t x, input mat_t y);
    int acc = 0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int k = 0; k < 16; k++)
          acc += int'(x[i*16+k]) * int'(y[k*16+j]);
    return acc;
  endfunction

  mat_t a1, a2, c1, c2;
  logic [32:0] sb[$];

  // Behavioural core: stores writes, computes on start, raises done after LAT cycles.
  int stale_hold = 0;
  bit core_dead  = 1'b0;
  bit pend       = 1'b0;
  int cnt        = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      done   = 1'b0;
      sum_in = '0;
      pend   = 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_sel[0]) c2[wr_addr] = wr_data;
        else           c1[wr_addr] = wr_data;
      end
      if (start) begin
        pend   = 1'b1;
        cnt    = 0;
        sum_in = 32'hDEAD_BEEF;
        if (stale_hold == 0) done = 1'b0;
      end else if (pend) begin
        cnt++;
        if (cnt == stale_hold) done = 1'b0;
        if (cnt >= stale_hold + LAT && !core_dead) begin
          sum_in = mat_sum(c1, c2);
          done   = 1'b1;
          pend   = 1'b0;
        end
      end
    end
  end

  int          cyc = 0;
  logic [9:0]  widx = '0;
  int          wr_count = 0, first_wr_cyc = 0, last_wr_cyc = 0;
  int          start_count = 0, start_cyc = 0, rr_cyc = 0, rv_cyc = 0, n_res = 0;
  logic        hs, rr, rvh, prev_wr = 1'b0, prev_rv = 1'b0, prev_start = 1'b0, hold_p = 1'b0;
  logic [20:0] sd;
  logic [32:0] hold_v;

  always @(posedge clk) begin
    cyc++;
    hs  = rst_n && s_valid && s_ready;
    rr  = rst_n && cmd_rerun;
    rvh = rst_n && r_valid && r_ready;
    sd  = s_data;
    if (rr) rr_cyc = cyc;
    if (rvh) begin
      if (sb.size() == 0) check_eq("sb_extra", 64'(sb.size()), 1);
      else begin
        check_eq("result", {r_err, r_data}, sb.pop_front());
        n_res++;
      end
    end
    if (rst_n && r_valid && !r_ready) begin
      hold_v = {r_err, r_data};
      hold_p = 1'b1;
    end else hold_p = 1'b0;
    #1;
    if (!rst_n) begin
      widx = '0; prev_wr = 1'b0; prev_rv = 1'b0; prev_start = 1'b0; hold_p = 1'b0;
    end else begin
      if (hold_p) check_eq("r_hold", {r_valid, r_err, r_data}, {1'b1, hold_v});
      if (hs) begin
        check_eq("wr", {wr_en, wr_sel, wr_addr, wr_data}, {1'b1, 1'b0, widx[8], widx[7:0], sd});
        widx = (widx == 10'd511) ? 10'd0 : widx + 10'd1;
        if (wr_count == 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        wr_count++;
      end else if (wr_en) check_eq("wr_spurious", 64'(wr_en), 0);
      if (start) begin
        check_eq("start_src", {prev_wr | rr, wr_en, prev_start}, 3'b100);
        start_cyc = cyc;
        start_count++;
      end
      if (r_valid && !prev_rv) rv_cyc = cyc;
      prev_wr = wr_en; prev_rv = r_valid; prev_start = start;
    end
  end

  task automatic fill(input int kind);
    for (int i = 0; i < 256; i++) begin
      case (kind)
        0:       begin a1[i] = (i / 16 == i % 16) ? 21'sd1 : 21'sd0; a2[i] = a1[i]; end
        1:       begin a1[i] = 21'sd1;  a2[i] = 21'sd1; end
        2:       begin a1[i] = -21'sd1; a2[i] = 21'sd1; end
        default: begin
          a1[i] = 21'(int'($urandom_range(0, 8)) - 4);
          a2[i] = 21'(int'($urandom_range(0, 8)) - 4);
        end
      endcase
    end
  endtask

  task automatic clear_stats();
    wr_count = 0; start_count = 0;
  endtask

  task automatic drive_stream(input int count, input bit gaps);
    int g;
    for (int i = 0; i < count; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid = 1'b0;
          @(negedge clk);
        end
      end
      s_valid = 1'b1;
      s_data  = (i < 256) ? a1[i] : a2[i-256];
      g = 0;
      while (!s_ready && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (g >= 200) check_eq("s_ready_stuck", 64'(s_ready), 1);
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic load_full(input bit gaps);
    clear_stats();
    sb.push_back({1'b0, mat_sum(a1, a2)});
    drive_stream(512, gaps);
  endtask

  task automatic pulse_rerun();
    clear_stats();
    cmd_rerun = 1'b1;
    @(negedge clk);
    cmd_rerun = 1'b0;
  endtask

  task automatic wait_results(input int limit);
    int g = 0;
    while (sb.size() != 0 && g < limit) begin
      @(negedge clk);
      g++;
    end
    check_eq("sb_drain", 64'(sb.size()), 0);
    repeat (3) @(negedge clk);
    check_eq("idle_after", {busy, r_valid}, 0);
  endtask

  initial begin
    int g, res0;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; cmd_rerun = 1'b0; r_ready = 1'b1;
    @(negedge clk);
    check_eq("reset_outs", {wr_en, wr_sel, wr_addr, wr_data, start, r_valid, r_data, r_err, busy}, 0);
    check_eq("reset_ready", 64'(s_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity x identity, continuous stream
    fill(0);
    load_full(1'b0);
    wait_results(2000);
    check_eq("t1_wr_count", wr_count, 512);
    check_eq("t1_wr_span", last_wr_cyc - first_wr_cyc, 511);
    check_eq("t1_start_cyc", start_cyc, last_wr_cyc + 1);
    check_eq("t1_start_count", start_count, 1);

    // All ones, then -1 x 1
    fill(1);
    load_full(1'b0);
    wait_results(2000);
    fill(2);
    load_full(1'b0);
    wait_results(2000);

    // Rerun with resident matrices, then rerun against a stale done level
    sb.push_back({1'b0, 32'hFFFF_F000});
    pulse_rerun();
    wait_results(2000);
    check_eq("t4_start_cyc", start_cyc, rr_cyc);
    check_eq("t4_no_writes", wr_count, 0);
    check_eq("t4_start_count", start_count, 1);
    stale_hold = 5;
    sb.push_back({1'b0, 32'hFFFF_F000});
    pulse_rerun();
    wait_results(2000);
    stale_hold = 0;

    // Random data, bursty valid, result backpressure
    fill(3);
    r_ready = 1'b0;
    res0 = n_res;
    load_full(1'b1);
    g = 0;
    while (!r_valid && g < 3000) begin
      @(negedge clk);
      g++;
    end
    repeat (20) @(negedge clk);
    check_eq("t3_valid_held", 64'(r_valid), 1);
    r_ready = 1'b1;
    wait_results(2000);
    check_eq("t3_one_result", n_res - res0, 1);
    check_eq("t3_wr_count", wr_count, 512);

    // Core never completes
    core_dead = 1'b1;
    sb.push_back({1'b1, 32'h0});
    pulse_rerun();
    wait_results(TIMEOUT + 2000);
    check_eq("t5_timeout_lat", rv_cyc - start_cyc, TIMEOUT + 1);
    core_dead = 1'b0;

    // Asynchronous reset mid-load, then a clean reload
    fill(3);
    drive_stream(100, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_async_reset", {wr_en, wr_sel, wr_addr, wr_data, start, r_valid, r_data, r_err, busy}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill(3);
    load_full(1'b0);
    wait_results(2000);
    check_eq("t6_wr_count", wr_count, 512);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
